// File: rtl/accum_8b.sv
// accum_8b: 8-bit sequential accumulator with IDLE/RUN/DONE control.
// Optional saturation on overflow: define ACCUM_8B_SATURATE_EN.
module accum_8b (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic       sel,
  input  logic       start,
  input  logic [3:0] count,
  output logic [7:0] sum,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [3:0]  rem_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [7:0]  mux_out;
  logic [8:0]  add9;
  logic        carry;

  // operand select and 9-bit add; carry-out drives wrap or clamp
  always_comb begin
    mux_out = sel ? in1 : in0;
    add9    = {1'b0, acc_q} + {1'b0, mux_out};
    carry   = add9[8];
`ifdef ACCUM_8B_SATURATE_EN
    acc_d   = carry ? 8'hFF : add9[7:0];
`else
    acc_d   = add9[7:0];
`endif
  end

  // control FSM with registered status outputs and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      rem_q   <= 4'd0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            acc_q <= 8'd0;
            ovf_q <= 1'b0;
            rem_q <= count;
            if (count != 4'd0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_q - 4'd1;
          if (carry) ovf_q <= 1'b1;
          if (rem_q == 4'd1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = acc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_accum_8b.sv
// tb_accum_8b: randomized self-checking bench for accum_8b.
// Reference model sums selected operands with plain integer arithmetic.
module tb_accum_8b;

  logic       clk;
  logic       reset;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       sel;
  logic       start;
  logic [3:0] count;
  logic [7:0] sum;
  logic       busy;
  logic       done;
  logic       ovf;

`ifdef ACCUM_8B_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] t_in0 [16];
  logic [7:0] t_in1 [16];
  logic       t_sel [16];
  bit         use_tbl;

  accum_8b dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .sel   (sel),
    .start (start),
    .count (count),
    .sum   (sum),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one complete run and record what the DUT showed.
  task automatic run_one(
    input  logic [3:0] c,
    input  bit         hold,
    output int         bcyc,
    output int         dcnt,
    output logic [7:0] sd,
    output logic       od,
    output logic [7:0] sa,
    output logic [7:0] es,
    output bit         eo
  );
    int m;
    int op;
    bcyc = 0;
    dcnt = 0;
    m = 0;
    eo = 1'b0;
    start = 1'b1;
    count = c;
    step();
    start = hold;
    for (int i = 0; i < int'(c); i++) begin
      if (use_tbl) begin
        in0 = t_in0[i];
        in1 = t_in1[i];
        sel = t_sel[i];
      end else begin
        in0 = 8'($urandom);
        in1 = 8'($urandom);
        sel = 1'($urandom);
      end
      op = sel ? int'(in1) : int'(in0);
      if (m + op > 255) begin
        eo = 1'b1;
        m = SAT ? 255 : m + op - 256;
      end else begin
        m = m + op;
      end
      bcyc += int'(busy);
      dcnt += int'(done);
      step();
    end
    sd = sum;
    od = ovf;
    dcnt += int'(done);
    bcyc += int'(busy);
    start = 1'b0;
    in0 = 8'($urandom);
    in1 = 8'($urandom);
    step();
    dcnt += int'(done);
    bcyc += int'(busy);
    step();
    dcnt += int'(done);
    sa = sum;
    es = 8'(m);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    count = 4'd0;
    in0 = 8'd0;
    in1 = 8'd0;
    sel = 1'b0;
    step();
    step();
    total_cnt++;
    if ({sum, busy, done, ovf} !== 11'd0) begin
      $display("FAIL reset_state: got sum=%0d busy=%b done=%b ovf=%b want 0",
               sum, busy, done, ovf);
    end else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if ({sum, busy, done} !== 10'd0) begin
      $display("FAIL reset_idle_hold: got sum=%0d busy=%b done=%b want 0",
               sum, busy, done);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    use_tbl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_in0[i] = 8'd5;
      t_in1[i] = 8'd77;
      t_sel[i] = 1'b0;
    end
    run_one(4'd3, 1'b0, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (b !== 3) $display("FAIL basic_busy: got %0d cycles want 3", b);
    else pass_cnt++;
    total_cnt++;
    if (d !== 1) $display("FAIL basic_done: got %0d pulses want 1", d);
    else pass_cnt++;
    total_cnt++;
    if (sd !== 8'd15 || od !== 1'b0)
      $display("FAIL basic_sum: got sum=%0d ovf=%b want 15 ovf=0", sd, od);
    else pass_cnt++;
    total_cnt++;
    if (sa !== 8'd15) $display("FAIL basic_stable: got %0d want 15", sa);
    else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    use_tbl = 1'b0;
    run_one(4'd0, 1'b0, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (b !== 0 || d !== 1)
      $display("FAIL zero_ctrl: got busy=%0d done=%0d want 0 and 1", b, d);
    else pass_cnt++;
    total_cnt++;
    if (sd !== 8'd0 || od !== 1'b0)
      $display("FAIL zero_sum: got sum=%0d ovf=%b want 0 ovf=0", sd, od);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int b, d;
    logic [7:0] sd, sa, es;
    logic [7:0] want;
    logic od;
    bit eo;
    use_tbl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_in0[i] = 8'd3;
      t_in1[i] = 8'd200;
      t_sel[i] = 1'b1;
    end
    want = SAT ? 8'd255 : 8'd144;
    run_one(4'd2, 1'b0, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (sd !== want || od !== 1'b1)
      $display("FAIL ovf_sum: got sum=%0d ovf=%b want %0d ovf=1", sd, od, want);
    else pass_cnt++;
    total_cnt++;
    if (sa !== want) $display("FAIL ovf_stable: got %0d want %0d", sa, want);
    else pass_cnt++;
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf);
    else pass_cnt++;
  endtask

  task automatic test_sel_toggle();
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    use_tbl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_in0[i] = 8'd1;
      t_in1[i] = 8'd10;
      t_sel[i] = 1'(i % 2);
    end
    run_one(4'd4, 1'b0, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (sd !== 8'd22 || od !== 1'b0)
      $display("FAIL sel_toggle: got sum=%0d ovf=%b want 22 ovf=0", sd, od);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    use_tbl = 1'b0;
    run_one(4'd7, 1'b1, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (b !== 7 || d !== 1)
      $display("FAIL start_in_run: got busy=%0d done=%0d want 7 and 1", b, d);
    else pass_cnt++;
    total_cnt++;
    if (sd !== es || od !== eo)
      $display("FAIL start_in_run_sum: got %0d/%b want %0d/%b", sd, od, es, eo);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    count = 4'd2;
    in0 = 8'd4;
    sel = 1'b0;
    step();
    step();
    step();
    total_cnt++;
    if (done !== 1'b1 || sum !== 8'd8)
      $display("FAIL b2b_first: got done=%b sum=%0d want 1 and 8", done, sum);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    step();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || sum !== 8'd0)
      $display("FAIL b2b_retrigger: got busy=%b sum=%0d want 1 and 0", busy, sum);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (done !== 1'b1 || sum !== 8'd8)
      $display("FAIL b2b_second: got done=%b sum=%0d want 1 and 8", done, sum);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_reset_abort();
    int dc;
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    start = 1'b1;
    count = 4'd5;
    in0 = 8'd50;
    sel = 1'b0;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if ({sum, busy, done, ovf} !== 11'd0)
      $display("FAIL abort_state: got sum=%0d busy=%b done=%b ovf=%b want 0",
               sum, busy, done, ovf);
    else pass_cnt++;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      dc += int'(done);
      step();
    end
    total_cnt++;
    if (dc !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", dc);
    else pass_cnt++;
    use_tbl = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_in0[i] = 8'd9;
      t_in1[i] = 8'd99;
      t_sel[i] = 1'b0;
    end
    run_one(4'd1, 1'b0, b, d, sd, od, sa, es, eo);
    total_cnt++;
    if (sd !== 8'd9 || d !== 1)
      $display("FAIL abort_fresh: got sum=%0d done=%0d want 9 and 1", sd, d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int b, d;
    logic [7:0] sd, sa, es;
    logic od;
    bit eo;
    logic [3:0] c;
    use_tbl = 1'b0;
    for (int r = 0; r < 24; r++) begin
      c = 4'($urandom_range(0, 15));
      run_one(c, 1'($urandom), b, d, sd, od, sa, es, eo);
      total_cnt++;
      if (b !== int'(c) || d !== 1)
        $display("FAIL rand_ctrl[%0d]: got busy=%0d done=%0d want %0d and 1",
                 r, b, d, c);
      else pass_cnt++;
      total_cnt++;
      if (sd !== es || od !== eo || sa !== es)
        $display("FAIL rand_sum[%0d]: got %0d/%b/%0d want %0d/%b",
                 r, sd, od, sa, es, eo);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_sel_toggle();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
